// File: rtl/cordic_folded.sv
// cordic_folded: iterative (folded) CORDIC engine. One shared add/shift
// datapath performs one micro-rotation per cycle, followed by a single gain
// compensation / saturation step. Supports rotation and vectoring modes.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   x_i, y_i, z_i  signed input operands (WIDTH bits, FRAC fractional bits)
//   mode_i         0 = rotation, 1 = vectoring; sampled with the operands
//   vld_i          input valid
//   rdy_o          input ready (combinational from state and rdy_i)
//   x_o, y_o, z_o  registered signed results
//   vld_o          output valid
//   rdy_i          downstream ready
module cordic_folded #(
  parameter int WIDTH     = 20,
  parameter int FRAC      = 15,
  parameter int N_ITER    = 16,
  parameter int GAIN_COMP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  input  logic                    mode_i,
  input  logic                    vld_i,
  output logic                    rdy_o,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o,
  output logic                    vld_o,
  input  logic                    rdy_i
);

  // Internal x/y carry two guard bits so the CORDIC gain and the
  // pre-rotation negation of the most negative input cannot overflow.
  localparam int unsigned IW = WIDTH + 2;
  localparam int unsigned CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int unsigned KW = FRAC + 2;
  localparam int unsigned PW = IW + KW;

  // Fixed-point scale used for elaboration-time arctangent evaluation.
  localparam longint ONE60 = longint'(1) << 60;

  // atan(1/m) scaled by 2^60 via the alternating Taylor series.
  function automatic longint atan_inv(input longint m);
    longint sum;
    longint pw;
    longint term;
    int     k;
    bit     stop;
    sum  = 0;
    pw   = m;
    k    = 0;
    stop = 1'b0;
    while (!stop) begin
      term = (ONE60 / pw) / longint'(2 * k + 1);
      if ((k % 2) == 0) sum = sum + term;
      else              sum = sum - term;
      k = k + 1;
      if (term == 0 || pw > (ONE60 / m) / m) stop = 1'b1;
      else                                   pw = pw * m * m;
    end
    return sum;
  endfunction

  // round(atan(2^-i) * 2^FRAC); atan(1) from Machin's formula.
  function automatic longint atan_q(input int i);
    longint r;
    if (i == 0) r = 4 * atan_inv(5) - atan_inv(239);
    else        r = atan_inv(longint'(1) << i);
    return (r + (longint'(1) << (59 - FRAC))) >>> (60 - FRAC);
  endfunction

  // round(c * 1e-7 * 2^FRAC) for a constant given to seven decimals.
  function automatic longint round_scaled(input longint c);
    return ((c << FRAC) + 64'sd5000000) / 64'sd10000000;
  endfunction

  localparam logic signed [WIDTH-1:0] PI2     = WIDTH'(round_scaled(15707963));
  localparam logic signed [WIDTH-1:0] NEG_PI2 = -PI2;
  localparam logic signed [KW-1:0]    INVK    = KW'(round_scaled(6072529));
  localparam logic signed [IW-1:0]    SAT_HI  = IW'((longint'(1) << (WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0]    SAT_LO  = IW'(-(longint'(1) << (WIDTH - 1)));

  // Clamp a guard-bit word into the output range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_HI)      return WIDTH'(SAT_HI);
    else if (v < SAT_LO) return WIDTH'(SAT_LO);
    else                 return WIDTH'(v);
  endfunction

  // Arctangent table, constant per entry.
  logic signed [WIDTH-1:0] atan_tab [N_ITER];
  for (genvar g = 0; g < N_ITER; g++) begin : g_atan
    assign atan_tab[g] = WIDTH'(atan_q(g));
  end

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic [CW-1:0]           cnt;
  logic                    mode_r;
  logic signed [IW-1:0]    x_r;
  logic signed [IW-1:0]    y_r;
  logic signed [WIDTH-1:0] z_r;

  logic signed [IW-1:0]    x_in;
  logic signed [IW-1:0]    y_in;
  logic signed [IW-1:0]    x_pre;
  logic signed [IW-1:0]    y_pre;
  logic signed [WIDTH-1:0] z_pre;

  logic                    d_pos;
  logic signed [IW-1:0]    x_sh;
  logic signed [IW-1:0]    y_sh;
  logic signed [IW-1:0]    x_it;
  logic signed [IW-1:0]    y_it;
  logic signed [WIDTH-1:0] z_it;

  logic signed [PW-1:0]    x_prod;
  logic signed [PW-1:0]    y_prod;
  logic signed [IW-1:0]    x_sc;
  logic signed [IW-1:0]    y_sc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, ready and transfer decode.
  always_comb begin
    state_next = state;
    rdy_o      = 1'b0;
    case (state)
      IDLE:    rdy_o = 1'b1;
      DONE:    rdy_o = rdy_i;
      default: rdy_o = 1'b0;
    endcase
    accept = vld_i & rdy_o;
    case (state)
      IDLE:    if (accept) state_next = ITER;
      ITER:    if (cnt == CW'(N_ITER - 1)) state_next = SCALE;
      SCALE:   state_next = DONE;
      DONE:    if (rdy_i) state_next = accept ? ITER : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Quadrant pre-rotation so the remaining angle fits the CORDIC range.
  always_comb begin
    x_in  = IW'(x_i);
    y_in  = IW'(y_i);
    x_pre = x_in;
    y_pre = y_in;
    z_pre = z_i;
    if (!mode_i) begin
      if (z_i > PI2) begin
        x_pre = -y_in;
        y_pre = x_in;
        z_pre = z_i - PI2;
      end else if (z_i < NEG_PI2) begin
        x_pre = y_in;
        y_pre = -x_in;
        z_pre = z_i + PI2;
      end
    end else if (x_i < 0) begin
      if (y_i >= 0) begin
        x_pre = y_in;
        y_pre = -x_in;
        z_pre = z_i + PI2;
      end else begin
        x_pre = -y_in;
        y_pre = x_in;
        z_pre = z_i - PI2;
      end
    end
  end

  // One micro-rotation on the shared add/shift datapath.
  always_comb begin
    d_pos = mode_r ? y_r[IW-1] : ~z_r[WIDTH-1];
    x_sh  = x_r >>> cnt;
    y_sh  = y_r >>> cnt;
    if (d_pos) begin
      x_it = x_r - y_sh;
      y_it = y_r + x_sh;
      z_it = z_r - atan_tab[cnt];
    end else begin
      x_it = x_r + y_sh;
      y_it = y_r - x_sh;
      z_it = z_r + atan_tab[cnt];
    end
  end

  // Gain compensation; the arithmetic shift truncates toward -inf.
  always_comb begin
    x_prod = PW'(x_r) * PW'(INVK);
    y_prod = PW'(y_r) * PW'(INVK);
    if (GAIN_COMP != 0) begin
      x_sc = IW'(x_prod >>> FRAC);
      y_sc = IW'(y_prod >>> FRAC);
    end else begin
      x_sc = x_r;
      y_sc = y_r;
    end
  end

  // Working registers and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
      cnt    <= '0;
      x_o    <= '0;
      y_o    <= '0;
      z_o    <= '0;
      vld_o  <= 1'b0;
    end else begin
      if (accept) begin
        x_r    <= x_pre;
        y_r    <= y_pre;
        z_r    <= z_pre;
        mode_r <= mode_i;
        cnt    <= '0;
      end else if (state == ITER) begin
        x_r <= x_it;
        y_r <= y_it;
        z_r <= z_it;
        cnt <= cnt + CW'(1);
      end
      if (state == SCALE) begin
        x_o   <= sat(x_sc);
        y_o   <= sat(y_sc);
        z_o   <= z_r;
        vld_o <= 1'b1;
      end else if (state == DONE && rdy_i) begin
        vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_folded.sv
// tb_cordic_folded: scoreboard bench for cordic_folded. Stimulus pushes the
// hand-computed expected result when an operand transfer happens; monitors
// pop and compare on every output handshake. A second instance covers the
// uncompensated-gain build.
`timescale 1ns/1ps
module tb_cordic_folded;

  localparam int W = 20;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    z;
    int    tx;
    int    ty;
    int    tz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic signed [W-1:0] x_i, y_i, z_i;
  logic                mode_i, vld_i, rdy_o, vld_o, rdy_i;
  logic signed [W-1:0] x_o, y_o, z_o;

  logic signed [W-1:0] bx_i, by_i, bz_i;
  logic                bmode_i, bvld_i, brdy_o, bvld_o, brdy_i;
  logic signed [W-1:0] bx_o, by_o, bz_o;

  cordic_folded #(.WIDTH(W), .FRAC(15), .N_ITER(16), .GAIN_COMP(1)) dut (
    .clk(clk), .rst(rst), .x_i(x_i), .y_i(y_i), .z_i(z_i), .mode_i(mode_i),
    .vld_i(vld_i), .rdy_o(rdy_o), .x_o(x_o), .y_o(y_o), .z_o(z_o),
    .vld_o(vld_o), .rdy_i(rdy_i));

  cordic_folded #(.WIDTH(W), .FRAC(15), .N_ITER(16), .GAIN_COMP(0)) dut_raw (
    .clk(clk), .rst(rst), .x_i(bx_i), .y_i(by_i), .z_i(bz_i), .mode_i(bmode_i),
    .vld_i(bvld_i), .rdy_o(brdy_o), .x_o(bx_o), .y_o(by_o), .z_o(bz_o),
    .vld_o(bvld_o), .rdy_i(brdy_i));

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp, input int tol);
    total++;
    if ((act - exp) <= tol && (exp - act) <= tol) passed++;
    else $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
  endtask

  function automatic exp_t mk(input string n, input int x, input int y, input int z,
                              input int tx, input int ty, input int tz);
    exp_t e;
    e.name = n; e.x = x; e.y = y; e.z = z; e.tx = tx; e.ty = ty; e.tz = tz;
    return e;
  endfunction

  // Monitor, compensated instance.
  always @(negedge clk) begin
    if (!rst && vld_o && rdy_i) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got vld_o=1 x_o=%0d, want no output", x_o);
      end else begin
        ea = qa.pop_front();
        check({ea.name, "_x"}, int'(x_o), ea.x, ea.tx);
        check({ea.name, "_y"}, int'(y_o), ea.y, ea.ty);
        check({ea.name, "_z"}, int'(z_o), ea.z, ea.tz);
      end
    end
  end

  // Monitor, raw-gain instance.
  always @(negedge clk) begin
    if (!rst && bvld_o && brdy_i) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out_raw: got vld_o=1 x_o=%0d, want no output", bx_o);
      end else begin
        eb = qb.pop_front();
        check({eb.name, "_x"}, int'(bx_o), eb.x, eb.tx);
        check({eb.name, "_y"}, int'(by_o), eb.y, eb.ty);
        check({eb.name, "_z"}, int'(bz_o), eb.z, eb.tz);
      end
    end
  end

  // Present an operand set until accepted; acc is the cycle of the accepting edge's preceding negedge.
  task automatic send_a(input int x, input int y, input int z, input logic m,
                        input bit push, input exp_t e, output int acc);
    bit ok;
    ok     = 1'b0;
    acc    = 0;
    x_i    = W'(x);
    y_i    = W'(y);
    z_i    = W'(z);
    mode_i = m;
    vld_i  = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (rdy_o) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    check({e.name, "_accept"}, int'(ok), 1, 0);
    @(posedge clk);
    if (push && ok) qa.push_back(e);
    #1;
    vld_i = 1'b0;
  endtask

  task automatic send_b(input int x, input int y, input int z, input logic m,
                        input exp_t e, output int acc);
    bit ok;
    ok      = 1'b0;
    acc     = 0;
    bx_i    = W'(x);
    by_i    = W'(y);
    bz_i    = W'(z);
    bmode_i = m;
    bvld_i  = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (brdy_o) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    check({e.name, "_accept"}, int'(ok), 1, 0);
    @(posedge clk);
    if (ok) qb.push_back(e);
    #1;
    bvld_i = 1'b0;
  endtask

  // Bounded wait for the next negedge with vld_o high.
  task automatic wait_vld_a(input string name, output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (vld_o) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    check({name, "_vld_seen"}, int'(ok), 1, 0);
  endtask

  task automatic wait_vld_b(input string name, output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bvld_o) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    check({name, "_vld_seen"}, int'(ok), 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3, c4;
    int seen;
    logic signed [W-1:0] hx, hy, hz;

    rst = 1'b1;
    x_i = '0; y_i = '0; z_i = '0; mode_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b1;
    bx_i = '0; by_i = '0; bz_i = '0; bmode_i = 1'b0; bvld_i = 1'b0; brdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_vld_o", int'(vld_o), 0, 0);
    check("rst_rdy_o", int'(rdy_o), 1, 0);
    check("rst_x_o", int'(x_o), 0, 0);
    check("rst_y_o", int'(y_o), 0, 0);
    check("rst_z_o", int'(z_o), 0, 0);
    @(posedge clk); #1;

    // Rotation by +pi/4, then a back-to-back -pi/4 accepted in DONE.
    send_a(32768, 0, 25736, 1'b0, 1'b1, mk("rot_p45", 23170, 23170, 0, 4, 4, 4), c0);
    send_a(32768, 0, -25736, 1'b0, 1'b1, mk("rot_m45", 23170, -23170, 0, 4, 4, 4), c1);
    check("latency_rot_p45", c1 - (c0 + 1), 17, 0);
    wait_vld_a("rot_m45", c2);
    check("b2b_spacing", c2 - c1, 18, 0);

    // Vectoring under 10+ cycles of backpressure, new operand held meanwhile.
    @(posedge clk); #1;
    rdy_i = 1'b0;
    send_a(32768, 32768, 0, 1'b1, 1'b1, mk("vec_45", 46341, 0, 25736, 4, 4, 4), c0);
    wait_vld_a("vec_45", c1);
    check("latency_vec_45", c1 - (c0 + 1), 17, 0);
    hx = x_o; hy = y_o; hz = z_o;
    x_i = W'(32768); y_i = W'(0); z_i = W'(102944); mode_i = 1'b0; vld_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_hold", int'(x_o == hx && y_o == hy && z_o == hz && vld_o), 1, 0);
      check("bp_rdy_o", int'(rdy_o), 0, 0);
    end
    @(posedge clk); #1;
    rdy_i = 1'b1;
    send_a(32768, 0, 102944, 1'b0, 1'b1, mk("rot_pi", -32768, 0, 0, 6, 6, 6), c3);
    wait_vld_a("rot_pi", c4);
    check("latency_after_bp", c4 - (c3 + 1), 17, 0);

    // Vectoring pre-rotation, both left-half quadrants.
    @(posedge clk); #1;
    send_a(-32768, 0, 0, 1'b1, 1'b1, mk("vec_q2", 32768, 0, 102944, 4, 4, 6), c0);
    wait_vld_a("vec_q2", c1);
    @(posedge clk); #1;
    send_a(-32768, -32768, 0, 1'b1, 1'b1, mk("vec_q3", 46341, 0, -77208, 6, 6, 6), c0);
    wait_vld_a("vec_q3", c1);

    // Rotation exactly at +/-pi/2: no pre-rotation applied.
    @(posedge clk); #1;
    send_a(32768, 0, 51472, 1'b0, 1'b1, mk("rot_p90", 0, 32768, 0, 6, 6, 6), c0);
    wait_vld_a("rot_p90", c1);
    @(posedge clk); #1;
    send_a(32768, 0, -51472, 1'b0, 1'b1, mk("rot_m90", 0, -32768, 0, 6, 6, 6), c0);
    wait_vld_a("rot_m90", c1);

    // Reset mid-ITER, then reset held against a transfer attempt in IDLE.
    @(posedge clk); #1;
    send_a(32768, 0, 25736, 1'b0, 1'b0, mk("rst_victim", 0, 0, 0, 0, 0, 0), c0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    x_i = W'(1000); y_i = W'(0); z_i = W'(0); mode_i = 1'b0; vld_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    vld_i = 1'b0;
    @(negedge clk);
    check("post_rst_rdy_o", int'(rdy_o), 1, 0);
    check("post_rst_vld_o", int'(vld_o), 0, 0);
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (vld_o) seen++;
    end
    check("rst_no_vld", seen, 0, 0);

    // Raw-gain instance: K scaling and saturation at both rails.
    @(posedge clk); #1;
    send_b(32768, 0, 0, 1'b0, mk("raw_k", 53961, 0, 0, 4, 4, 4), c0);
    wait_vld_b("raw_k", c1);
    check("latency_raw", c1 - (c0 + 1), 17, 0);
    @(posedge clk); #1;
    send_b(400000, 0, 0, 1'b0, mk("raw_sat_hi", 524287, 0, 0, 0, 40, 4), c0);
    wait_vld_b("raw_sat_hi", c1);
    @(posedge clk); #1;
    send_b(-400000, 0, 0, 1'b0, mk("raw_sat_lo", -524288, 0, 0, 0, 40, 4), c0);
    wait_vld_b("raw_sat_lo", c1);

    repeat (3) @(posedge clk);
    check("queue_drained", qa.size(), 0, 0);
    check("queue_drained_raw", qb.size(), 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
